mc_controller: RTL and testbench

Multicycle MIPS control unit, successor to the single-cycle main/ALU decoder pair. Moore FSM sequences each instruction through fetch/decode/execute/memory/writeback steps, sharing one ALU and one memory port. Adds a memory-ready handshake, a bounded memory-wait timeout and illegal-opcode reporting. Sits beside the multicycle datapath and drives all its muxes and enables.

---
 rtl/mc_ctrl_pkg.sv | 50 +++++
 rtl/mc_aludec.sv | 37 +++
 rtl/mc_controller.sv | 192 +++++++++++++++++++
 tb/tb_mc_controller.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcode and
// funct constants, ALU operation selectors and ALU control codes.
package mc_ctrl_pkg;

  // Controller states; StBranchNe is only reachable when MIPS_BNE_EN is defined.
  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRd    = 4'd3,
    StMemWb    = 4'd4,
    StMemWr    = 4'd5,
    StExec     = 4'd6,
    StAluWb    = 4'd7,
    StBranch   = 4'd8,
    StAddiEx   = 4'd9,
    StAddiWb   = 4'd10,
    StJump     = 4'd11,
    StBranchNe = 4'd12
  } state_e;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FunctAdd = 6'b100000;
  localparam logic [5:0] FunctSub = 6'b100010;
  localparam logic [5:0] FunctAnd = 6'b100100;
  localparam logic [5:0] FunctOr  = 6'b100101;
  localparam logic [5:0] FunctSlt = 6'b101010;

  // Internal ALU operation selector
  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  // ALU control codes seen by the datapath
  localparam logic [2:0] AlucAdd = 3'b010;
  localparam logic [2:0] AlucSub = 3'b110;
  localparam logic [2:0] AlucAnd = 3'b000;
  localparam logic [2:0] AlucOr  = 3'b001;
  localparam logic [2:0] AlucSlt = 3'b111;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps the controller's aluop and the instruction funct field to a
// 3-bit ALU control code, and flags whether funct is a supported R-type op.
module mc_aludec
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o,
  output logic       funct_valid_o
);

  logic [2:0] funct_aluc;

  // Decode funct independently of aluop so the writeback state can use the flag
  always_comb begin
    funct_valid_o = 1'b1;
    funct_aluc    = AlucAdd;
    case (funct_i)
      FunctAdd: funct_aluc = AlucAdd;
      FunctSub: funct_aluc = AlucSub;
      FunctAnd: funct_aluc = AlucAnd;
      FunctOr:  funct_aluc = AlucOr;
      FunctSlt: funct_aluc = AlucSlt;
      default:  funct_valid_o = 1'b0;
    endcase
  end

  // Select between fixed add/sub and the funct-driven operation
  always_comb begin
    case (aluop_i)
      AluOpSub:   alucontrol_o = AlucSub;
      AluOpFunct: alucontrol_o = funct_aluc;
      default:    alucontrol_o = AlucAdd;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit. Moore FSM sequencing fetch/decode/execute/
// memory/writeback with a memory-ready handshake, a bounded memory-wait
// timeout (MEM_TIMEOUT, 0 disables) and illegal opcode/funct reporting.
// Optional feature: define MIPS_BNE_EN to support bne (op 000101).
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned ALUC_W      = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        op,
  input  logic [5:0]        funct,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              pcen,
  output logic              iord,
  output logic              memwrite,
  output logic              irwrite,
  output logic              regdst,
  output logic              memtoreg,
  output logic              regwrite,
  output logic              alusrca,
  output logic [1:0]        alusrcb,
  output logic [1:0]        pcsrc,
  output logic [ALUC_W-1:0] alucontrol,
  output logic              illegal,
  output logic              memerr
);

  localparam int unsigned CntW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntMax      = '1;
  // Counter value seen on the MEM_TIMEOUT-th consecutive waiting cycle
  localparam logic [CntW-1:0] TimeoutLast = CntW'(MEM_TIMEOUT - 1);

  state_e          state_q, state_d, dec_state;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic       illegal_op, mem_wait, timeout;
  logic       pcwrite, branch, branch_ne;
  logic       irwrite_raw, memwrite_raw, regwrite_raw, illegal_raw;
  logic [1:0] aluop;
  logic [2:0] aluc3;
  logic       funct_valid;

  // Next state, illegal-opcode detection and memory wait counter
  always_comb begin
    state_d    = state_q;
    illegal_op = 1'b0;
    case (state_q)
      StFetch: if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (op)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExec;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
`ifdef MIPS_BNE_EN
          OpBne:      state_d = StBranchNe;
`endif
          default: begin
            state_d    = StFetch;
            illegal_op = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        if (op == OpSw)      state_d = StMemWr;
        else if (op == OpLw) state_d = StMemRd;
        else                 state_d = StFetch;
      end
      StMemRd:  if (mem_ready) state_d = StMemWb;
      StMemWr:  if (mem_ready) state_d = StFetch;
      StExec:   state_d = StAluWb;
      StAddiEx: state_d = StAddiWb;
      default:  state_d = StFetch;
    endcase

    mem_wait = ((state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr))
               && !mem_ready;
    timeout  = (MEM_TIMEOUT != 0) && mem_wait && (cnt_q == TimeoutLast);
    if (timeout) state_d = StFetch;

    // A waiting state never changes state except on timeout, so clearing on
    // !mem_wait or timeout covers every state change.
    if (!mem_wait || timeout) cnt_d = '0;
    else if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
    else                      cnt_d = cnt_q;
  end

  // State and wait counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore output decode; during reset the outputs show FETCH values
  always_comb begin
    dec_state    = reset ? StFetch : state_q;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    branch_ne    = 1'b0;
    iord         = 1'b0;
    irwrite_raw  = 1'b0;
    memwrite_raw = 1'b0;
    regwrite_raw = 1'b0;
    illegal_raw  = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    aluop        = AluOpAdd;
    case (dec_state)
      StFetch: begin
        alusrcb     = 2'b01;
        irwrite_raw = mem_ready;
        pcwrite     = mem_ready;
      end
      StDecode: begin
        alusrcb     = 2'b11;
        illegal_raw = illegal_op;
      end
      StMemAdr: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      StMemRd: iord = 1'b1;
      StMemWb: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
      end
      StMemWr: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
      end
      StExec: begin
        alusrca = 1'b1;
        aluop   = AluOpFunct;
      end
      StAluWb: begin
        regdst       = 1'b1;
        regwrite_raw = funct_valid;
        illegal_raw  = !funct_valid;
      end
      StBranch, StBranchNe: begin
        alusrca   = 1'b1;
        aluop     = AluOpSub;
        pcsrc     = 2'b01;
        branch    = (dec_state == StBranch);
        branch_ne = (dec_state == StBranchNe);
      end
      StAddiEx: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      StAddiWb: regwrite_raw = 1'b1;
      StJump: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  mc_aludec u_aludec (
    .aluop_i       (aluop),
    .funct_i       (funct),
    .alucontrol_o  (aluc3),
    .funct_valid_o (funct_valid)
  );

  // Enables are suppressed during reset and on the timeout cycle
  always_comb begin
    pcen       = !reset && !timeout &&
                 (pcwrite || (branch && zero) || (branch_ne && !zero));
    irwrite    = !reset && !timeout && irwrite_raw;
    memwrite   = !reset && !timeout && memwrite_raw;
    regwrite   = !reset && !timeout && regwrite_raw;
    illegal    = !reset && illegal_raw;
    memerr     = !reset && timeout;
    alucontrol = ALUC_W'(aluc3);
  end

endmodule

// File: tb/tb_mc_controller.sv
// Directed, table-driven bench for mc_controller: each row is one clock cycle
// of inputs plus the full expected output vector, followed by hand-written
// timeout sequences.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       illegal, memerr;

  int checks = 0;
  int errors = 0;

  mc_controller #(.MEM_TIMEOUT(16), .ALUC_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pcen       (pcen),
    .iord       (iord),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .illegal    (illegal),
    .memerr     (memerr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        rdy;
    logic [16:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  // {pcen,iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,aluc,ill,merr}
  function automatic logic [16:0] ex(input logic pc, io, mw, irw, rd, mtr, rw, asa,
                                     input logic [1:0] asb, pcs, input logic [2:0] aluc,
                                     input logic ill, merr);
    return {pc, io, mw, irw, rd, mtr, rw, asa, asb, pcs, aluc, ill, merr};
  endfunction

  task automatic add(input logic r, input logic [5:0] o, f, input logic z, rdy,
                     input logic [16:0] e, input string n);
    vec_t v;
    v.rst = r; v.op = o; v.funct = f; v.zero = z; v.rdy = rdy; v.exp = e; v.name = n;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs after the falling edge, compare before the next rise
  task automatic step(input vec_t v);
    logic [16:0] got;
    @(negedge clk);
    reset = v.rst; op = v.op; funct = v.funct; zero = v.zero; mem_ready = v.rdy;
    #1;
    got = {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
           alusrcb, pcsrc, alucontrol, illegal, memerr};
    checks++;
    if (got !== v.exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", v.name, got, v.exp);
    end
  endtask

  task automatic cyc(input logic r, input logic [5:0] o, f, input logic z, rdy,
                     input logic [16:0] e, input string n);
    vec_t v;
    v.rst = r; v.op = o; v.funct = f; v.zero = z; v.rdy = rdy; v.exp = e; v.name = n;
    step(v);
  endtask

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000, JMP = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  logic [16:0] e_rst, e_f1, e_fto, e_dec, e_deci, e_ma, e_mr, e_mwb, e_mw, e_mwto;
  logic [16:0] e_awb, e_awbi, e_br1, e_br0, e_aiwb, e_j;

  initial begin
    e_rst  = ex(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0, 0);
    e_f1   = ex(1, 0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0, 0);
    e_fto  = ex(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0, 1);
    e_dec  = ex(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 0, 0);
    e_deci = ex(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 1, 0);
    e_ma   = ex(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0, 0);
    e_mr   = ex(0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0, 0);
    e_mwb  = ex(0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 3'b010, 0, 0);
    e_mw   = ex(0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0, 0);
    e_mwto = ex(0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0, 1);
    e_awb  = ex(0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 3'b010, 0, 0);
    e_awbi = ex(0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b010, 1, 0);
    e_br1  = ex(1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 0, 0);
    e_br0  = ex(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 0, 0);
    e_aiwb = ex(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b010, 0, 0);
    e_j    = ex(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b010, 0, 0);

    // Reset with mem_ready high: enables must stay low
    add(1, LW, 6'h00, 0, 1, e_rst, "reset0");
    add(1, LW, 6'h00, 0, 1, e_rst, "reset1");
    // lw, mem_ready tied high
    add(0, LW, 6'h00, 0, 1, e_f1,  "lw_fetch");
    add(0, LW, 6'h00, 0, 1, e_dec, "lw_decode");
    add(0, LW, 6'h00, 0, 1, e_ma,  "lw_memadr");
    add(0, LW, 6'h00, 0, 1, e_mr,  "lw_memrd");
    add(0, LW, 6'h00, 0, 1, e_mwb, "lw_memwb");
    // sw with three wait cycles in MEMWR
    add(0, SW, 6'h00, 0, 1, e_f1,  "sw_fetch");
    add(0, SW, 6'h00, 0, 1, e_dec, "sw_decode");
    add(0, SW, 6'h00, 0, 1, e_ma,  "sw_memadr");
    for (int i = 0; i < 3; i++) add(0, SW, 6'h00, 0, 0, e_mw, "sw_memwr_wait");
    add(0, SW, 6'h00, 0, 1, e_mw,  "sw_memwr_done");
    // beq taken and not taken
    add(0, BEQ, 6'h00, 1, 1, e_f1,  "beq1_fetch");
    add(0, BEQ, 6'h00, 1, 1, e_dec, "beq1_decode");
    add(0, BEQ, 6'h00, 1, 1, e_br1, "beq1_branch");
    add(0, BEQ, 6'h00, 0, 1, e_f1,  "beq0_fetch");
    add(0, BEQ, 6'h00, 0, 1, e_dec, "beq0_decode");
    add(0, BEQ, 6'h00, 0, 1, e_br0, "beq0_branch");
    // R-type or, slt, sub, then unsupported funct
    add(0, RT, 6'b100101, 0, 1, e_f1,  "or_fetch");
    add(0, RT, 6'b100101, 0, 1, e_dec, "or_decode");
    add(0, RT, 6'b100101, 0, 1, ex(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b001, 0, 0),
        "or_exec");
    add(0, RT, 6'b100101, 0, 1, e_awb, "or_aluwb");
    add(0, RT, 6'b101010, 0, 1, e_f1,  "slt_fetch");
    add(0, RT, 6'b101010, 0, 1, e_dec, "slt_decode");
    add(0, RT, 6'b101010, 0, 1, ex(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b111, 0, 0),
        "slt_exec");
    add(0, RT, 6'b101010, 0, 1, e_awb, "slt_aluwb");
    add(0, RT, 6'b100010, 0, 1, e_f1,  "sub_fetch");
    add(0, RT, 6'b100010, 0, 1, e_dec, "sub_decode");
    add(0, RT, 6'b100010, 0, 1, ex(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b110, 0, 0),
        "sub_exec");
    add(0, RT, 6'b100010, 0, 1, e_awb, "sub_aluwb");
    add(0, RT, 6'b000011, 0, 1, e_f1,  "badfn_fetch");
    add(0, RT, 6'b000011, 0, 1, e_dec, "badfn_decode");
    add(0, RT, 6'b000011, 0, 1, ex(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b010, 0, 0),
        "badfn_exec");
    add(0, RT, 6'b000011, 0, 1, e_awbi, "badfn_aluwb");
    // addi, jump, illegal opcode
    add(0, ADDI, 6'h00, 0, 1, e_f1,   "addi_fetch");
    add(0, ADDI, 6'h00, 0, 1, e_dec,  "addi_decode");
    add(0, ADDI, 6'h00, 0, 1, e_ma,   "addi_ex");
    add(0, ADDI, 6'h00, 0, 1, e_aiwb, "addi_wb");
    add(0, JMP, 6'h00, 0, 1, e_f1,  "j_fetch");
    add(0, JMP, 6'h00, 0, 1, e_dec, "j_decode");
    add(0, JMP, 6'h00, 0, 1, e_j,   "j_jump");
    add(0, BAD, 6'h00, 0, 1, e_f1,   "badop_fetch");
    add(0, BAD, 6'h00, 0, 1, e_deci, "badop_decode");
    add(0, BAD, 6'h00, 0, 1, e_f1,   "badop_refetch");
    add(0, BAD, 6'h00, 0, 1, e_deci, "badop_decode2");
    // bne
    add(0, BNE, 6'h00, 0, 1, e_f1, "bne_fetch");
`ifdef MIPS_BNE_EN
    add(0, BNE, 6'h00, 0, 1, e_dec, "bne0_decode");
    add(0, BNE, 6'h00, 0, 1, e_br1, "bne0_branch");
    add(0, BNE, 6'h00, 1, 1, e_f1,  "bne1_fetch");
    add(0, BNE, 6'h00, 1, 1, e_dec, "bne1_decode");
    add(0, BNE, 6'h00, 1, 1, e_br0, "bne1_branch");
`else
    add(0, BNE, 6'h00, 0, 1, e_deci, "bne_illegal");
`endif
    // MEMRD: mem_ready on the 16th waiting cycle wins over the timeout
    add(0, LW, 6'h00, 0, 1, e_f1,  "lwwin_fetch");
    add(0, LW, 6'h00, 0, 1, e_dec, "lwwin_decode");
    add(0, LW, 6'h00, 0, 1, e_ma,  "lwwin_memadr");
    for (int i = 0; i < 15; i++) add(0, LW, 6'h00, 0, 0, e_mr, "lwwin_memrd_wait");
    add(0, LW, 6'h00, 0, 1, e_mr,  "lwwin_memrd_ready");
    add(0, LW, 6'h00, 0, 1, e_mwb, "lwwin_memwb");
    // Reset while in MEMRD aborts the load
    add(0, LW, 6'h00, 0, 1, e_f1,  "lwrst_fetch");
    add(0, LW, 6'h00, 0, 1, e_dec, "lwrst_decode");
    add(0, LW, 6'h00, 0, 1, e_ma,  "lwrst_memadr");
    add(0, LW, 6'h00, 0, 0, e_mr,  "lwrst_memrd");
    add(1, LW, 6'h00, 0, 1, e_rst, "lwrst_reset");
    add(0, JMP, 6'h00, 0, 1, e_f1,  "lwrst_refetch");
    add(0, JMP, 6'h00, 0, 1, e_dec, "lwrst_decode_j");
    add(0, JMP, 6'h00, 0, 1, e_j,   "lwrst_jump");

    foreach (vecs[i]) step(vecs[i]);

    // FETCH timeout: memerr on the 16th waiting cycle, irwrite never set
    for (int i = 1; i <= 16; i++)
      cyc(0, LW, 6'h00, 0, 0, (i == 16) ? e_fto : e_rst, "fetch_wait");
    cyc(0, LW, 6'h00, 0, 0, e_rst, "fetch_after_timeout");
    cyc(0, SW, 6'h00, 0, 1, e_f1,  "swto_fetch");
    cyc(0, SW, 6'h00, 0, 1, e_dec, "swto_decode");
    cyc(0, SW, 6'h00, 0, 1, e_ma,  "swto_memadr");
    // MEMWR timeout: memwrite dropped on the timeout cycle, then FETCH
    for (int i = 1; i <= 16; i++)
      cyc(0, SW, 6'h00, 0, 0, (i == 16) ? e_mwto : e_mw, "swto_memwr");
    cyc(0, JMP, 6'h00, 0, 1, e_f1,  "swto_refetch");
    cyc(0, JMP, 6'h00, 0, 1, e_dec, "swto_decode_j");
    cyc(0, JMP, 6'h00, 0, 1, e_j,   "swto_jump");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
